seg7_capture: RTL and testbench
===============================

# seg7_capture

Captures a stream of 7-segment patterns, one digit per beat, and decodes them back into two hex bytes. It is the receive-side counterpart of the team's hex-to-7-segment display driver. It sits between a segment-bus sampler (or the display driver under loopback test) and any logic that needs the numeric value. Frames of four digits (S low, S high, A low, A high) are reassembled into `hex_out_S` / `hex_out_A`, with per-digit pattern-validity flags and a valid/ready output handshake.

## Interface
Parameters:
- `SEG_ACTIVE_LOW`, default 1: 1 = lit segment is 0 (board convention). 0 = input is inverted before decode.

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `seg_valid`  in  1  a segment pattern is presented on `seg_in`
- `seg_ready`  out  1  block accepts a beat this cycle
- `seg_in`  in  7  segment pattern; bit 6 = g … bit 0 = a
- `frame_start`  in  1  qualifies the current beat as digit 0 of a frame
- `out_valid`  out  1  decoded frame available
- `out_ready`  in  1  consumer takes the frame
- `hex_out_S`  out  8  {digit1, digit0}
- `hex_out_A`  out  8  {digit3, digit2}
- `err_mask`  out  4  bit n = digit n pattern was invalid
- `sync_lost`  out  1  one-cycle pulse: beat dropped while waiting for `frame_start`

## Operation
- Decode table (active-low, hex of `seg_in`):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - Any other pattern is invalid: nibble = 0, `err_mask` bit set.
- A beat is accepted when `seg_valid && seg_ready`. No beat is accepted in any other cycle.
- FSM states: COLLECT (2-bit digit counter `dcnt`) and FULL.
- COLLECT:
  - `seg_ready` = 1.
  - Accepted beat with `frame_start`=1: stored as digit 0, `dcnt`←1. Any partial frame is discarded and its err bits cleared. This applies at any `dcnt` value.
  - Accepted beat, `frame_start`=0, `dcnt`=0: the beat is dropped and `sync_lost` pulses.
  - Accepted beat, `frame_start`=0, `dcnt`=1..3: stored as digit `dcnt`, `dcnt`++.
  - Accepting digit 3 moves the FSM to FULL. Registered outputs and `err_mask` update on the same edge.
- FULL:
  - `seg_ready` = 0, `out_valid` = 1.
  - Outputs are held stable until `out_ready`.
  - On `out_valid && out_ready`: go to COLLECT, `dcnt`←0, `out_valid`←0. `hex_out_*` / `err_mask` keep their last values.
- Reset values: state COLLECT, `dcnt`=0, `out_valid`=0, `hex_out_S`=`hex_out_A`=0x00, `err_mask`=0, `sync_lost`=0. `seg_ready` is 1 from the first edge after reset release.
- Reset mid-frame or while FULL: everything is discarded and nothing is emitted.

## Timing
- `seg_ready` is combinational from the state only. It never depends on `seg_valid`.
- `out_valid` rises on the edge that accepts digit 3, i.e. a latency of 1 cycle from the last beat.
- Minimum frame period is 5 cycles: 4 beats plus 1 handoff cycle. Back-to-back frames are possible only when `out_ready` is held high.
- `sync_lost` is registered and is high exactly one cycle after the dropped beat.
- `frame_start` is ignored when no beat is accepted.

## Structure
- Package `seg7_pkg`:
  - 16 pattern constants `SEG7_0`…`SEG7_F` (7-bit, active-low).
  - State enum `{COLLECT, FULL}`.
  - Constant `DIGITS_PER_FRAME = 4`.
  - The display driver is refactored to use the same constants.
- Sub-module `seg7_decode`: combinational, `seg_in[6:0]` → {nibble[3:0], valid}. It is instantiated once, on the input path.

## Test plan
- Nominal frame: beats 46(fs=1), 30, 12, 08 → `hex_out_S`=0x3C, `hex_out_A`=0xA5, `err_mask`=0, `out_valid` rises 1 cycle after the 4th beat.
- Backpressure:
  - After a full frame, hold `out_ready`=0 for 10 cycles → `out_valid`=1, `seg_ready`=0, outputs constant, no beat accepted.
  - Then raise `out_ready` → `seg_ready`=1 on the next cycle.
- Invalid pattern: beats 40(fs=1), 79, 7F, 0E → `hex_out_S`=0x10, `hex_out_A`=0xF0, `err_mask`=4'b0100.
- Resync:
  - Beats 24(fs=1), 30, then 19(fs=1), 12, 02, 78 → `hex_out_S`=0x54, `hex_out_A`=0x76.
  - Only one `out_valid` occurs.
- Unsynchronised start: after reset, beats 00, 10 (fs=0) → two `sync_lost` pulses, no output. A following fs=1 frame decodes normally.
- Reset mid-frame: assert `rst_n`=0 after 2 beats (asynchronous, mid-cycle) → all outputs 0 immediately. A subsequent complete frame decodes correctly.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the display driver and the capture block.
// Patterns are active-low (lit segment = 0), bit 6 = g ... bit 0 = a.
package seg7_pkg;

  localparam logic [6:0] SEG7_0 = 7'h40;
  localparam logic [6:0] SEG7_1 = 7'h79;
  localparam logic [6:0] SEG7_2 = 7'h24;
  localparam logic [6:0] SEG7_3 = 7'h30;
  localparam logic [6:0] SEG7_4 = 7'h19;
  localparam logic [6:0] SEG7_5 = 7'h12;
  localparam logic [6:0] SEG7_6 = 7'h02;
  localparam logic [6:0] SEG7_7 = 7'h78;
  localparam logic [6:0] SEG7_8 = 7'h00;
  localparam logic [6:0] SEG7_9 = 7'h10;
  localparam logic [6:0] SEG7_A = 7'h08;
  localparam logic [6:0] SEG7_B = 7'h03;
  localparam logic [6:0] SEG7_C = 7'h46;
  localparam logic [6:0] SEG7_D = 7'h21;
  localparam logic [6:0] SEG7_E = 7'h06;
  localparam logic [6:0] SEG7_F = 7'h0E;

  localparam int unsigned DIGITS_PER_FRAME = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } cap_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern decoder.
//   seg_in [6:0] : active-low segment pattern (bit 6 = g ... bit 0 = a)
//   nibble [3:0] : decoded hex digit (0 when the pattern is not recognised)
//   valid        : 1 when seg_in matches one of the 16 hex glyphs
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_in,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = '0;
    valid  = 1'b1;
    case (seg_in)
      SEG7_0:  nibble = 4'h0;
      SEG7_1:  nibble = 4'h1;
      SEG7_2:  nibble = 4'h2;
      SEG7_3:  nibble = 4'h3;
      SEG7_4:  nibble = 4'h4;
      SEG7_5:  nibble = 4'h5;
      SEG7_6:  nibble = 4'h6;
      SEG7_7:  nibble = 4'h7;
      SEG7_8:  nibble = 4'h8;
      SEG7_9:  nibble = 4'h9;
      SEG7_A:  nibble = 4'hA;
      SEG7_B:  nibble = 4'hB;
      SEG7_C:  nibble = 4'hC;
      SEG7_D:  nibble = 4'hD;
      SEG7_E:  nibble = 4'hE;
      SEG7_F:  nibble = 4'hF;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Reassembles a stream of 7-segment digit patterns into two hex bytes.
// Frame = 4 beats: S low, S high, A low, A high; frame_start marks digit 0.
//   clk, rst_n         : clock, asynchronous active-low reset
//   seg_valid/seg_ready: input beat handshake, seg_in[6:0] pattern
//   frame_start        : current beat is digit 0 of a frame
//   out_valid/out_ready: decoded frame handshake
//   hex_out_S/hex_out_A: {digit1,digit0} / {digit3,digit2}
//   err_mask[3:0]      : bit n set when digit n pattern was invalid
//   sync_lost          : one-cycle pulse after a beat dropped while unsynced
module seg7_capture
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seg_valid,
  output logic       seg_ready,
  input  logic [6:0] seg_in,
  input  logic       frame_start,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] hex_out_S,
  output logic [7:0] hex_out_A,
  output logic [3:0] err_mask,
  output logic       sync_lost
);

  localparam logic [1:0] LAST_DIGIT = 2'(DIGITS_PER_FRAME - 1);

  cap_state_e  state_q, state_d;
  logic [1:0]  dcnt_q, dcnt_d;
  logic [3:0]  dig0_q, dig0_d, dig1_q, dig1_d, dig2_q, dig2_d;
  logic [2:0]  err_q, err_d;
  logic [7:0]  hex_s_q, hex_s_d, hex_a_q, hex_a_d;
  logic [3:0]  err_mask_q, err_mask_d;
  logic        sync_lost_q, sync_lost_d;

  logic [6:0]  seg_norm;
  logic [3:0]  nib;
  logic        nib_ok;
  logic        beat_acc;

  assign seg_norm = SEG_ACTIVE_LOW ? seg_in : ~seg_in;

  seg7_decode u_decode (
    .seg_in (seg_norm),
    .nibble (nib),
    .valid  (nib_ok)
  );

  assign seg_ready = (state_q == COLLECT);
  assign out_valid = (state_q == FULL);
  assign beat_acc  = seg_valid && seg_ready;

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    dig0_d      = dig0_q;
    dig1_d      = dig1_q;
    dig2_d      = dig2_q;
    err_d       = err_q;
    hex_s_d     = hex_s_q;
    hex_a_d     = hex_a_q;
    err_mask_d  = err_mask_q;
    sync_lost_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (beat_acc) begin
          if (frame_start) begin
            // Restart: any partial frame and its error bits are thrown away.
            dig0_d = nib;
            dig1_d = '0;
            dig2_d = '0;
            err_d  = {2'b00, ~nib_ok};
            dcnt_d = 2'd1;
          end else if (dcnt_q == 2'd0) begin
            sync_lost_d = 1'b1;
          end else if (dcnt_q == LAST_DIGIT) begin
            hex_s_d    = {dig1_q, dig0_q};
            hex_a_d    = {nib, dig2_q};
            err_mask_d = {~nib_ok, err_q};
            state_d    = FULL;
          end else begin
            if (dcnt_q == 2'd1) begin
              dig1_d   = nib;
              err_d[1] = ~nib_ok;
            end else begin
              dig2_d   = nib;
              err_d[2] = ~nib_ok;
            end
            dcnt_d = dcnt_q + 2'd1;
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = COLLECT;
          dcnt_d  = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      dcnt_q      <= '0;
      dig0_q      <= '0;
      dig1_q      <= '0;
      dig2_q      <= '0;
      err_q       <= '0;
      hex_s_q     <= '0;
      hex_a_q     <= '0;
      err_mask_q  <= '0;
      sync_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      dig0_q      <= dig0_d;
      dig1_q      <= dig1_d;
      dig2_q      <= dig2_d;
      err_q       <= err_d;
      hex_s_q     <= hex_s_d;
      hex_a_q     <= hex_a_d;
      err_mask_q  <= err_mask_d;
      sync_lost_q <= sync_lost_d;
    end
  end

  assign hex_out_S = hex_s_q;
  assign hex_out_A = hex_a_q;
  assign err_mask  = err_mask_q;
  assign sync_lost = sync_lost_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: frame vector table, hand-written
// corner sequences, then randomized traffic against a queue-based model.
module tb_seg7_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seg_valid = 1'b0;
  logic       seg_ready;
  logic [6:0] seg_in = '0;
  logic       frame_start = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] hex_out_S;
  logic [7:0] hex_out_A;
  logic [3:0] err_mask;
  logic       sync_lost;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_capture #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_valid   (seg_valid),
    .seg_ready   (seg_ready),
    .seg_in      (seg_in),
    .frame_start (frame_start),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .hex_out_S   (hex_out_S),
    .hex_out_A   (hex_out_A),
    .err_mask    (err_mask),
    .sync_lost   (sync_lost)
  );

  // Glyph table indexed by hex value.
  logic [6:0] seg_tab [16];

  typedef struct packed {
    logic [3:0][6:0] pats;   // pats[0] is digit 0
    logic [7:0]      s;
    logic [7:0]      a;
    logic [3:0]      err;
  } vec_t;

  vec_t vecs [7];

  typedef struct packed {
    logic [3:0] n;
    logic       e;
  } dig_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] p, output logic [3:0] n, output logic e);
    n = '0;
    e = 1'b1;
    for (int i = 0; i < 16; i++)
      if (seg_tab[i] == p) begin
        n = 4'(i);
        e = 1'b0;
      end
  endfunction

  // Present one beat for exactly one rising edge, then sample 1 time unit later.
  task automatic beat(input logic [6:0] p, input logic fs);
    seg_valid   = 1'b1;
    seg_in      = p;
    frame_start = fs;
    @(posedge clk);
    #1;
    seg_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] s_hold, a_hold;
    logic [3:0] e_hold;
    int         ov_count;
    dig_t       q[$];
    dig_t       d;
    logic       m_full;
    logic [7:0] m_s, m_a;
    logic [3:0] m_err;
    logic       exp_sync;

    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;

    vecs[0] = '{pats: {7'h08, 7'h12, 7'h30, 7'h46}, s: 8'h3C, a: 8'hA5, err: 4'b0000};
    vecs[1] = '{pats: {7'h0E, 7'h7F, 7'h79, 7'h40}, s: 8'h10, a: 8'hF0, err: 4'b0100};
    vecs[2] = '{pats: {7'h30, 7'h24, 7'h79, 7'h40}, s: 8'h10, a: 8'h32, err: 4'b0000};
    vecs[3] = '{pats: {7'h46, 7'h21, 7'h06, 7'h0E}, s: 8'hEF, a: 8'hCD, err: 4'b0000};
    vecs[4] = '{pats: {7'h02, 7'h00, 7'h78, 7'h7F}, s: 8'h70, a: 8'h68, err: 4'b0001};
    vecs[5] = '{pats: {7'h7F, 7'h7F, 7'h7F, 7'h7F}, s: 8'h00, a: 8'h00, err: 4'b1111};
    vecs[6] = '{pats: {7'h10, 7'h19, 7'h02, 7'h03}, s: 8'h6B, a: 8'h94, err: 4'b0000};

    // Reset values
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_hex_S", 32'(hex_out_S), 32'h00);
    chk("rst_hex_A", 32'(hex_out_A), 32'h00);
    chk("rst_err", 32'(err_mask), 32'h0);
    chk("rst_sync_lost", 32'(sync_lost), 32'd0);
    do_reset();
    chk("rst_seg_ready", 32'(seg_ready), 32'd1);

    // Frame vector table
    for (int v = 0; v < 7; v++) begin
      beat(vecs[v].pats[0], 1'b1);
      chk("vec_ov_d0", 32'(out_valid), 32'd0);
      beat(vecs[v].pats[1], 1'b0);
      beat(vecs[v].pats[2], 1'b0);
      chk("vec_ov_d2", 32'(out_valid), 32'd0);
      beat(vecs[v].pats[3], 1'b0);
      chk("vec_out_valid", 32'(out_valid), 32'd1);
      chk("vec_seg_ready", 32'(seg_ready), 32'd0);
      chk("vec_hex_S", 32'(hex_out_S), 32'(vecs[v].s));
      chk("vec_hex_A", 32'(hex_out_A), 32'(vecs[v].a));
      chk("vec_err", 32'(err_mask), 32'(vecs[v].err));
      handoff();
      chk("vec_post_ov", 32'(out_valid), 32'd0);
      chk("vec_post_ready", 32'(seg_ready), 32'd1);
      chk("vec_post_hex_S", 32'(hex_out_S), 32'(vecs[v].s));
      chk("vec_post_err", 32'(err_mask), 32'(vecs[v].err));
    end

    // Backpressure: beats offered while FULL must not be taken
    beat(7'h46, 1'b1); beat(7'h30, 1'b0); beat(7'h12, 1'b0); beat(7'h08, 1'b0);
    s_hold = hex_out_S; a_hold = hex_out_A; e_hold = err_mask;
    chk("bp_hex_S", 32'(s_hold), 32'h3C);
    for (int c = 0; c < 10; c++) begin
      seg_valid   = 1'b1;
      seg_in      = seg_tab[c];
      frame_start = c[0];
      @(posedge clk);
      #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_seg_ready", 32'(seg_ready), 32'd0);
      chk("bp_hold", {8'h0, hex_out_S, hex_out_A, 4'h0, err_mask},
          {8'h0, s_hold, a_hold, 4'h0, e_hold});
      chk("bp_sync_lost", 32'(sync_lost), 32'd0);
    end
    seg_valid = 1'b0;
    frame_start = 1'b0;
    handoff();
    chk("bp_release_ready", 32'(seg_ready), 32'd1);
    chk("bp_release_ov", 32'(out_valid), 32'd0);
    // Nothing offered during FULL may have been kept: an unflagged beat drops.
    beat(7'h40, 1'b0);
    chk("bp_no_partial", 32'(sync_lost), 32'd1);

    // Resync mid-frame: only the second frame is emitted
    ov_count = 0;
    beat(7'h24, 1'b1); ov_count += int'(out_valid);
    beat(7'h30, 1'b0); ov_count += int'(out_valid);
    beat(7'h19, 1'b1); ov_count += int'(out_valid);
    beat(7'h12, 1'b0); ov_count += int'(out_valid);
    beat(7'h02, 1'b0); ov_count += int'(out_valid);
    chk("resync_early_ov", 32'(ov_count), 32'd0);
    beat(7'h78, 1'b0);
    chk("resync_ov", 32'(out_valid), 32'd1);
    chk("resync_hex_S", 32'(hex_out_S), 32'h54);
    chk("resync_hex_A", 32'(hex_out_A), 32'h76);
    chk("resync_err", 32'(err_mask), 32'h0);
    handoff();

    // Unsynchronised start after reset
    do_reset();
    beat(7'h00, 1'b0);
    chk("unsync_pulse0", 32'(sync_lost), 32'd1);
    beat(7'h10, 1'b0);
    chk("unsync_pulse1", 32'(sync_lost), 32'd1);
    chk("unsync_ov", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("unsync_pulse_end", 32'(sync_lost), 32'd0);
    beat(7'h06, 1'b1); beat(7'h21, 1'b0); beat(7'h40, 1'b0); beat(7'h79, 1'b0);
    chk("unsync_frame_ov", 32'(out_valid), 32'd1);
    chk("unsync_frame_S", 32'(hex_out_S), 32'hDE);
    chk("unsync_frame_A", 32'(hex_out_A), 32'h10);
    handoff();

    // Asynchronous reset mid-frame
    beat(7'h24, 1'b1);
    beat(7'h30, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_hex_S", 32'(hex_out_S), 32'h00);
    chk("mrst_hex_A", 32'(hex_out_A), 32'h00);
    chk("mrst_err", 32'(err_mask), 32'h0);
    chk("mrst_ov", 32'(out_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Two stale digits must be gone: two more beats alone must not finish a frame.
    beat(7'h19, 1'b0);
    chk("mrst_stale_drop", 32'(sync_lost), 32'd1);
    beat(7'h08, 1'b1); beat(7'h03, 1'b0); beat(7'h46, 1'b0); beat(7'h21, 1'b0);
    chk("mrst_frame_ov", 32'(out_valid), 32'd1);
    chk("mrst_frame_S", 32'(hex_out_S), 32'hBA);
    chk("mrst_frame_A", 32'(hex_out_A), 32'hDC);
    handoff();

    // Randomized traffic against a queue-based frame model
    do_reset();
    m_full = 1'b0; m_s = '0; m_a = '0; m_err = '0;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      seg_valid   = ($urandom_range(0, 3) != 0);
      frame_start = ($urandom_range(0, 5) == 0);
      out_ready   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0) seg_in = seg_tab[$urandom_range(0, 15)];
      else seg_in = 7'($urandom);
      #1;
      chk("rnd_seg_ready", 32'(seg_ready), 32'(!m_full));
      exp_sync = 1'b0;
      if (m_full) begin
        if (out_ready) m_full = 1'b0;
      end else if (seg_valid) begin
        ref_decode(seg_in, d.n, d.e);
        if (frame_start) begin
          q.delete();
          q.push_back(d);
        end else if (q.size() == 0) begin
          exp_sync = 1'b1;
        end else begin
          q.push_back(d);
          if (q.size() == 4) begin
            m_s    = {q[1].n, q[0].n};
            m_a    = {q[3].n, q[2].n};
            m_err  = {q[3].e, q[2].e, q[1].e, q[0].e};
            m_full = 1'b1;
            q.delete();
          end
        end
      end
      @(posedge clk);
      #1;
      chk("rnd_out_valid", 32'(out_valid), 32'(m_full));
      chk("rnd_hex_S", 32'(hex_out_S), 32'(m_s));
      chk("rnd_hex_A", 32'(hex_out_A), 32'(m_a));
      chk("rnd_err", 32'(err_mask), 32'(m_err));
      chk("rnd_sync_lost", 32'(sync_lost), 32'(exp_sync));
    end
    seg_valid = 1'b0;
    frame_start = 1'b0;
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
